caliptra_fpga_rt_regs: RTL and testbench
========================================

// Module: caliptra_fpga_rt_regs
// PURPOSE
//  AXI4-Lite register block for the FPGA Caliptra wrapper. The PS drives Caliptra control/keys through it and reads status,
//  the log FIFO and the cycle count; it feeds the iTRNG FIFO. Hw-side fields are flat in/out ports; sw_acc strobes qualify FIFO access.
// PARAMETERS
//  ADDR_W     32      AXI address width; only ADDR[12:2] decoded, upper bits ignored
//  FIFO_BASE  0x1000  base of FIFO register group (interface group at 0x0000)
// PORTS
//  clk                  in   1   core clock, sole clock
//  rst_b                in   1   reset, asynchronous, active-low
//  s_axil_aw{valid,addr,prot}/awready  in/out  1,ADDR_W,3/1  write address
//  s_axil_w{valid,data,strb}/wready    in/out  1,32,4/1      write data
//  s_axil_bvalid,bresp/bready          out/in  1,2/1         write response
//  s_axil_ar{valid,addr,prot}/arready  in/out  1,ADDR_W,3/1  read address
//  s_axil_rvalid,rdata,rresp/rready    out/in  1,32,2/1      read data
//  gen_in_wires_o       out  64  {reg0,reg1} RW; obf_key_o out 256 {key7..key0}; pauser_o out 32; itrng_div_o out 32
//  ctl_pwrgood_o, ctl_rst_b_o, ctl_dbg_locked_o out 1 each; ctl_lifecycle_o out 2
//  gen_out_wires_i      in   64  {reg0,reg1} RO; status_i in 7 {mbx_flow_done,mbx_avail,rdy_rt,rdy_fw,rdy_fuses,err_nf,err_f}
//  cycle_count_i        in   32  RO cycle counter
//  log_char_i in 8; log_valid_i, log_empty_i, log_full_i in 1; log_rd_swacc_o out 1
//  itrng_data_o out 32; itrng_wr_swacc_o out 1; itrng_fifo_rst_o out 1; itrng_empty_i, itrng_full_i in 1
// BEHAVIOUR
//  Map (byte offsets): 0x00/0x04 gen_in[0/1] RW; 0x08/0x0C gen_out[0/1] RO; 0x10..0x2C obf_key[0..7] RW;
//   0x30 control RW: b0 pwrgood, b1 rst_b, b2 dbg_locked, b4:3 lifecycle; 0x34 status RO (status_i in b6:0);
//   0x38 pauser RW; 0x3C itrng_divisor RW; 0x40 cycle_count RO.
//   FIFO_BASE+0x0 log_fifo_data RO: b7:0 char, b8 valid; +0x4 log_status RO: b0 empty, b1 full;
//   +0x8 itrng_fifo_data RW 32; +0xC itrng_status: b0 empty RO, b1 full RO, b2 fifo_reset RW.
//  Reset (rst_b low, async): all RW fields 0, so pwrgood/rst_b/key outputs are low; awready=wready=arready=0, bvalid=rvalid=0,
//   bresp=rresp=0, rdata=0, swacc strobes 0.
//  Write: awready and wready high together for one cycle when awvalid&&wvalid&&!bvalid; fields update at that edge per wstrb
//   byte lane; bvalid rises next cycle, bresp=OKAY, holds until bready. No new write while bvalid high.
//  itrng_wr_swacc_o: 1-cycle pulse in handshake cycle of a write to +0x8; itrng_data_o shows new value the following cycle.
//  Read: arready high one cycle when arvalid&&!rvalid; rdata captured from live inputs/regs at that edge; rvalid next cycle,
//   rresp=OKAY, holds (data stable) until rready. No new read while rvalid high.
//  log_rd_swacc_o: 1-cycle pulse in AR handshake cycle for address +0x0; returned char/valid is pre-pop value.
//  Unmapped address: read 0, write ignored, response OKAY. RO-field writes ignored. Write and read channels independent;
//   simultaneous read+write in same cycle both proceed; read of the same register returns the old value.
//  Reset mid-transaction: aborted, valids drop immediately, no response issued.
// TESTING
//  Reset: rst_b=0 -> all outputs 0; release, read 0x30 -> 0x0, read 0x3C -> 0x0.
//  Write 0x30=0x1B, wstrb=0xF -> pwrgood=1, rst_b=1, dbg_locked=0, lifecycle=2'b11; readback 0x1B; bresp=0.
//  Byte strobe: write 0x10=0xAABBCCDD strb=0x2 after 0 -> obf_key[31:0]=0x0000CC00; key7 at 0x2C maps to obf_key_o[255:224].
//  Status/RO: status_i=7'h55, cycle_count_i=1234 -> read 0x34=0x55, 0x40=1234; write 0x40 ignored.
//  Log FIFO: log_char_i=0x41, log_valid_i=1, read FIFO_BASE -> rdata 0x141, log_rd_swacc_o one pulse; rready held low 3 cycles keeps rvalid/rdata.
//  iTRNG: write +0x8=0xDEADBEEF -> itrng_wr_swacc_o pulse, itrng_data_o=0xDEADBEEF next cycle; write +0xC=0x4 -> itrng_fifo_rst_o=1.

Source files
------------

// File: rtl/caliptra_fpga_rt_regs.sv
// AXI4-Lite register block for the FPGA Caliptra wrapper: control/key/pauser registers,
// status and cycle-count readback, log FIFO read port and iTRNG FIFO write port.
module caliptra_fpga_rt_regs #(
  parameter int          ADDR_W    = 32,
  parameter logic [31:0] FIFO_BASE = 32'h0000_1000
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              s_axil_awvalid,
  input  logic [ADDR_W-1:0] s_axil_awaddr,
  input  logic [2:0]        s_axil_awprot,
  output logic              s_axil_awready,
  input  logic              s_axil_wvalid,
  input  logic [31:0]       s_axil_wdata,
  input  logic [3:0]        s_axil_wstrb,
  output logic              s_axil_wready,
  output logic              s_axil_bvalid,
  output logic [1:0]        s_axil_bresp,
  input  logic              s_axil_bready,
  input  logic              s_axil_arvalid,
  input  logic [ADDR_W-1:0] s_axil_araddr,
  input  logic [2:0]        s_axil_arprot,
  output logic              s_axil_arready,
  output logic              s_axil_rvalid,
  output logic [31:0]       s_axil_rdata,
  output logic [1:0]        s_axil_rresp,
  input  logic              s_axil_rready,
  output logic [63:0]       gen_in_wires_o,
  output logic [255:0]      obf_key_o,
  output logic [31:0]       pauser_o,
  output logic [31:0]       itrng_div_o,
  output logic              ctl_pwrgood_o,
  output logic              ctl_rst_b_o,
  output logic              ctl_dbg_locked_o,
  output logic [1:0]        ctl_lifecycle_o,
  input  logic [63:0]       gen_out_wires_i,
  input  logic [6:0]        status_i,
  input  logic [31:0]       cycle_count_i,
  input  logic [7:0]        log_char_i,
  input  logic              log_valid_i,
  input  logic              log_empty_i,
  input  logic              log_full_i,
  output logic              log_rd_swacc_o,
  output logic [31:0]       itrng_data_o,
  output logic              itrng_wr_swacc_o,
  output logic              itrng_fifo_rst_o,
  input  logic              itrng_empty_i,
  input  logic              itrng_full_i
);

  // Word indices: the interface group sits at word 0, the FIFO group at FIFO_BASE.
  localparam logic [10:0] LOG_DATA_IDX   = FIFO_BASE[12:2];
  localparam logic [10:0] LOG_STAT_IDX   = FIFO_BASE[12:2] + 11'd1;
  localparam logic [10:0] ITRNG_DATA_IDX = FIFO_BASE[12:2] + 11'd2;
  localparam logic [10:0] ITRNG_STAT_IDX = FIFO_BASE[12:2] + 11'd3;

  logic [31:0]      gen_in0, gen_in1, pauser, itrng_div, itrng_data;
  logic [7:0][31:0] key;
  logic [4:0]       ctl;
  logic             fifo_rst;
  logic [10:0]      wr_idx, rd_idx;
  logic             wr_hs, rd_hs;
  logic [31:0]      rd_mux;
  logic             unused_bits;

  assign wr_idx = s_axil_awaddr[12:2];
  assign rd_idx = s_axil_araddr[12:2];
  assign wr_hs  = s_axil_awvalid && s_axil_wvalid && !s_axil_bvalid;
  assign rd_hs  = s_axil_arvalid && !s_axil_rvalid;

  assign s_axil_awready = wr_hs;
  assign s_axil_wready  = wr_hs;
  assign s_axil_arready = rd_hs;
  assign s_axil_bresp   = 2'b00;
  assign s_axil_rresp   = 2'b00;

  assign gen_in_wires_o   = {gen_in0, gen_in1};
  assign obf_key_o        = key;
  assign pauser_o         = pauser;
  assign itrng_div_o      = itrng_div;
  assign itrng_data_o     = itrng_data;
  assign itrng_fifo_rst_o = fifo_rst;
  assign ctl_pwrgood_o    = ctl[0];
  assign ctl_rst_b_o      = ctl[1];
  assign ctl_dbg_locked_o = ctl[2];
  assign ctl_lifecycle_o  = ctl[4:3];

  assign itrng_wr_swacc_o = wr_hs && (wr_idx == ITRNG_DATA_IDX);
  assign log_rd_swacc_o   = rd_hs && (rd_idx == LOG_DATA_IDX);

  assign unused_bits = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr[ADDR_W-1:13],
                         s_axil_awaddr[1:0], s_axil_araddr[ADDR_W-1:13], s_axil_araddr[1:0]};

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [3:0] strb);
    logic [31:0] res;
    res = old;
    for (int i = 0; i < 4; i++)
      if (strb[i]) res[8*i +: 8] = data[8*i +: 8];
    return res;
  endfunction

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      gen_in0       <= '0;
      gen_in1       <= '0;
      key           <= '0;
      ctl           <= '0;
      pauser        <= '0;
      itrng_div     <= '0;
      itrng_data    <= '0;
      fifo_rst      <= 1'b0;
      s_axil_bvalid <= 1'b0;
    end else begin
      if (wr_hs) begin
        s_axil_bvalid <= 1'b1;
        case (wr_idx)
          11'd0:          gen_in0    <= merge(gen_in0, s_axil_wdata, s_axil_wstrb);
          11'd1:          gen_in1    <= merge(gen_in1, s_axil_wdata, s_axil_wstrb);
          11'd12:         if (s_axil_wstrb[0]) ctl <= s_axil_wdata[4:0];
          11'd14:         pauser     <= merge(pauser, s_axil_wdata, s_axil_wstrb);
          11'd15:         itrng_div  <= merge(itrng_div, s_axil_wdata, s_axil_wstrb);
          ITRNG_DATA_IDX: itrng_data <= merge(itrng_data, s_axil_wdata, s_axil_wstrb);
          ITRNG_STAT_IDX: if (s_axil_wstrb[0]) fifo_rst <= s_axil_wdata[2];
          default:
            // Key words 0..7 live at word indices 4..11.
            if (wr_idx >= 11'd4 && wr_idx <= 11'd11)
              key[wr_idx[2:0] - 3'd4] <= merge(key[wr_idx[2:0] - 3'd4], s_axil_wdata, s_axil_wstrb);
        endcase
      end else if (s_axil_bready) begin
        s_axil_bvalid <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (rd_idx)
      11'd0:          rd_mux = gen_in0;
      11'd1:          rd_mux = gen_in1;
      11'd2:          rd_mux = gen_out_wires_i[63:32];
      11'd3:          rd_mux = gen_out_wires_i[31:0];
      11'd12:         rd_mux = {27'b0, ctl};
      11'd13:         rd_mux = {25'b0, status_i};
      11'd14:         rd_mux = pauser;
      11'd15:         rd_mux = itrng_div;
      11'd16:         rd_mux = cycle_count_i;
      LOG_DATA_IDX:   rd_mux = {23'b0, log_valid_i, log_char_i};
      LOG_STAT_IDX:   rd_mux = {30'b0, log_full_i, log_empty_i};
      ITRNG_DATA_IDX: rd_mux = itrng_data;
      ITRNG_STAT_IDX: rd_mux = {29'b0, fifo_rst, itrng_full_i, itrng_empty_i};
      default:
        if (rd_idx >= 11'd4 && rd_idx <= 11'd11) rd_mux = key[rd_idx[2:0] - 3'd4];
    endcase
  end

  // Read data is frozen at the AR handshake so it stays stable while rready is low.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      s_axil_rvalid <= 1'b0;
      s_axil_rdata  <= '0;
    end else if (rd_hs) begin
      s_axil_rvalid <= 1'b1;
      s_axil_rdata  <= rd_mux;
    end else if (s_axil_rready) begin
      s_axil_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_caliptra_fpga_rt_regs.sv
// Self-checking bench for caliptra_fpga_rt_regs: directed vector table, hand sequences
// for FIFO strobes/backpressure/reset abort, and randomized traffic against a word-map model.
module tb_caliptra_fpga_rt_regs;
  logic clk = 1'b0;
  logic rst_b;
  logic awvalid, wvalid, bready, arvalid, rready;
  logic [31:0] awaddr, araddr, wdata;
  logic [2:0] awprot, arprot;
  logic [3:0] wstrb;
  logic awready, wready, bvalid, arready, rvalid;
  logic [1:0] bresp, rresp;
  logic [31:0] rdata;
  logic [63:0] gen_in_wires, gen_out_wires;
  logic [255:0] obf_key;
  logic [31:0] pauser, itrng_div, cycle_count, itrng_data;
  logic pwrgood, ctl_rst_b, dbg_locked;
  logic [1:0] lifecycle;
  logic [6:0] status;
  logic [7:0] log_char;
  logic log_valid, log_empty, log_full, log_rd_swacc;
  logic itrng_wr_swacc, itrng_fifo_rst, itrng_empty, itrng_full;

  int checks = 0;
  int errors = 0;

  caliptra_fpga_rt_regs #(.ADDR_W(32), .FIFO_BASE(32'h1000)) dut (
    .clk(clk), .rst_b(rst_b),
    .s_axil_awvalid(awvalid), .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awready(awready),
    .s_axil_wvalid(wvalid), .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wready(wready),
    .s_axil_bvalid(bvalid), .s_axil_bresp(bresp), .s_axil_bready(bready),
    .s_axil_arvalid(arvalid), .s_axil_araddr(araddr), .s_axil_arprot(arprot), .s_axil_arready(arready),
    .s_axil_rvalid(rvalid), .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rready(rready),
    .gen_in_wires_o(gen_in_wires), .obf_key_o(obf_key), .pauser_o(pauser), .itrng_div_o(itrng_div),
    .ctl_pwrgood_o(pwrgood), .ctl_rst_b_o(ctl_rst_b), .ctl_dbg_locked_o(dbg_locked),
    .ctl_lifecycle_o(lifecycle), .gen_out_wires_i(gen_out_wires), .status_i(status),
    .cycle_count_i(cycle_count), .log_char_i(log_char), .log_valid_i(log_valid),
    .log_empty_i(log_empty), .log_full_i(log_full), .log_rd_swacc_o(log_rd_swacc),
    .itrng_data_o(itrng_data), .itrng_wr_swacc_o(itrng_wr_swacc), .itrng_fifo_rst_o(itrng_fifo_rst),
    .itrng_empty_i(itrng_empty), .itrng_full_i(itrng_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];
  logic [31:0] model[logic [31:0]];
  logic [31:0] rw_addrs[13];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s timeout actual=0 expected=1", name);
  endtask

  // Full write transaction; swacc returns itrng_wr_swacc_o as seen in the handshake cycle.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic swacc);
    int n;
    @(negedge clk);
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    #1;
    n = 0;
    while (!(awready && wready) && n < 16) begin @(negedge clk); #1; n++; end
    if (!(awready && wready)) timeout_fail("aw_handshake");
    swacc = itrng_wr_swacc;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    n = 0;
    while (!bvalid && n < 16) begin @(posedge clk); #1; n++; end
    if (!bvalid) timeout_fail("bvalid");
    else check_output("bresp", {30'b0, bresp}, 32'h0);
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data);
    int n;
    @(negedge clk);
    araddr = addr; arvalid = 1'b1;
    #1;
    n = 0;
    while (!arready && n < 16) begin @(negedge clk); #1; n++; end
    if (!arready) timeout_fail("ar_handshake");
    @(posedge clk); #1;
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 16) begin @(posedge clk); #1; n++; end
    if (!rvalid) timeout_fail("rvalid");
    else check_output("rresp", {30'b0, rresp}, 32'h0);
    data = rdata;
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  function automatic logic [31:0] model_mask(input logic [31:0] addr);
    return (addr == 32'h30) ? 32'h0000_001F : 32'hFFFF_FFFF;
  endfunction

  task automatic apply_stimulus();
    logic [31:0] rd;
    logic sw;
    foreach (vecs[i]) begin
      if (vecs[i].wr) axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, sw);
      else begin
        axi_read(vecs[i].addr, rd);
        check_output(vecs[i].name, rd, vecs[i].exp);
      end
    end
  endtask

  initial begin
    logic [31:0] rd, a, d, m, merged;
    logic [3:0] s;
    logic sw;
    int n;

    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    awaddr = 0; araddr = 0; wdata = 0; wstrb = 0; awprot = 0; arprot = 0;
    gen_out_wires = 64'h0123_4567_89AB_CDEF; status = 7'h55; cycle_count = 32'd1234;
    log_char = 8'h41; log_valid = 1'b1; log_empty = 1'b1; log_full = 1'b0;
    itrng_empty = 1'b1; itrng_full = 1'b0;
    rst_b = 1'b0;
    #23;
    check_output("reset_outputs",
      {31'b0, |{awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata, gen_in_wires, obf_key,
                pauser, itrng_div, pwrgood, ctl_rst_b, dbg_locked, lifecycle, log_rd_swacc,
                itrng_data, itrng_wr_swacc, itrng_fifo_rst}}, 32'h0);
    rst_b = 1'b1;
    repeat (2) @(posedge clk);

    vecs.push_back('{0, 32'h30, 0, 0, 32'h0, "ctl_after_reset"});
    vecs.push_back('{0, 32'h3C, 0, 0, 32'h0, "div_after_reset"});
    vecs.push_back('{1, 32'h30, 32'h1B, 4'hF, 0, ""});
    vecs.push_back('{0, 32'h30, 0, 0, 32'h1B, "ctl_readback"});
    vecs.push_back('{1, 32'h10, 32'hAABB_CCDD, 4'h2, 0, ""});
    vecs.push_back('{0, 32'h10, 0, 0, 32'h0000_CC00, "key0_strb"});
    vecs.push_back('{1, 32'h2C, 32'h1234_5678, 4'hF, 0, ""});
    vecs.push_back('{0, 32'h2C, 0, 0, 32'h1234_5678, "key7_readback"});
    vecs.push_back('{0, 32'h34, 0, 0, 32'h55, "status"});
    vecs.push_back('{1, 32'h40, 32'hFFFF_FFFF, 4'hF, 0, ""});
    vecs.push_back('{0, 32'h40, 0, 0, 32'd1234, "cycle_count_ro"});
    vecs.push_back('{0, 32'h08, 0, 0, 32'h0123_4567, "gen_out0"});
    vecs.push_back('{0, 32'h0C, 0, 0, 32'h89AB_CDEF, "gen_out1"});
    vecs.push_back('{1, 32'h00, 32'hCAFE_F00D, 4'hF, 0, ""});
    vecs.push_back('{0, 32'h00, 0, 0, 32'hCAFE_F00D, "gen_in0"});
    vecs.push_back('{1, 32'h200, 32'h5, 4'hF, 0, ""});
    vecs.push_back('{0, 32'h200, 0, 0, 32'h0, "unmapped"});
    vecs.push_back('{0, 32'h1004, 0, 0, 32'h1, "log_status"});
    vecs.push_back('{0, 32'hFFFF_0030, 0, 0, 32'h1B, "upper_addr_ignored"});
    apply_stimulus();

    check_output("ctl_outputs", {27'b0, lifecycle, dbg_locked, ctl_rst_b, pwrgood}, 32'h1B);
    check_output("obf_key_word0", obf_key[31:0], 32'h0000_CC00);
    check_output("obf_key_word7", obf_key[255:224], 32'h1234_5678);
    check_output("gen_in_reg0", gen_in_wires[63:32], 32'hCAFE_F00D);

    // Log FIFO read: pop strobe in the AR cycle only, data held under backpressure.
    @(negedge clk);
    araddr = 32'h1000; arvalid = 1'b1; #1;
    check_output("log_swacc_pulse", {31'b0, log_rd_swacc && arready}, 32'h1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    check_output("log_swacc_single", {31'b0, log_rd_swacc}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      check_output("log_hold", {rvalid ? 32'h1 : 32'h0} ^ rdata, 32'h141 ^ 32'h1);
      @(posedge clk); #1;
    end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    check_output("log_rvalid_drop", {31'b0, rvalid}, 32'h0);

    // iTRNG write strobe and delayed data.
    axi_write(32'h1008, 32'hDEAD_BEEF, 4'hF, sw);
    check_output("itrng_swacc", {31'b0, sw}, 32'h1);
    check_output("itrng_data", itrng_data, 32'hDEAD_BEEF);
    check_output("itrng_swacc_low", {31'b0, itrng_wr_swacc}, 32'h0);
    axi_write(32'h100C, 32'h4, 4'hF, sw);
    check_output("itrng_fifo_rst", {31'b0, itrng_fifo_rst}, 32'h1);
    axi_read(32'h100C, rd);
    check_output("itrng_status", rd, 32'h5);
    axi_write(32'h0030, 32'h1B, 4'hF, sw);
    check_output("ctl_write_no_itrng_swacc", {31'b0, sw}, 32'h0);

    // Simultaneous write and read of the same register returns the old value.
    @(negedge clk);
    awaddr = 32'h3C; wdata = 32'h77; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 32'h3C; arvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check_output("simul_bvalid", {31'b0, bvalid}, 32'h1);
    check_output("simul_read_old", rvalid ? rdata : 32'hFFFF_FFFF, 32'h0);
    check_output("simul_write_new", itrng_div, 32'h77);
    bready = 1'b1; rready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0; rready = 1'b0;

    // Randomized traffic against the word-map model.
    rw_addrs = '{32'h00, 32'h04, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h20, 32'h24, 32'h28, 32'h2C,
                 32'h30, 32'h38, 32'h3C};
    foreach (rw_addrs[i]) begin
      d = $urandom();
      axi_write(rw_addrs[i], d, 4'hF, sw);
      model[rw_addrs[i]] = d & model_mask(rw_addrs[i]);
    end
    for (int it = 0; it < 60; it++) begin
      a = rw_addrs[$urandom_range(0, 12)];
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom();
        s = 4'($urandom_range(0, 15));
        merged = model[a];
        for (int b = 0; b < 4; b++)
          if (s[b]) merged[8*b +: 8] = d[8*b +: 8];
        model[a] = merged & model_mask(a);
        axi_write(a | ($urandom() & 32'hFFFF_E000), d, s, sw);
      end else begin
        axi_read(a | ($urandom() & 32'hFFFF_E000), rd);
        check_output("rand_read", rd, model[a]);
      end
    end
    status = 7'($urandom());
    axi_read(32'h34, rd);
    check_output("rand_status", rd, {25'b0, status});
    check_output("model_pauser", pauser, model[32'h38]);
    check_output("model_div", itrng_div, model[32'h3C]);
    check_output("model_gen_in", gen_in_wires[31:0] ^ gen_in_wires[63:32], model[32'h04] ^ model[32'h00]);
    for (int k = 0; k < 8; k++) begin
      m = model[32'h10 + 32'(4 * k)];
      check_output("model_key", obf_key[32*k +: 32], m);
    end
    check_output("model_ctl", {27'b0, lifecycle, dbg_locked, ctl_rst_b, pwrgood}, model[32'h30]);

    // Reset in the middle of a write response aborts it.
    @(negedge clk);
    awaddr = 32'h38; wdata = 32'hA5A5_A5A5; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    check_output("abort_bvalid_before", {31'b0, bvalid}, 32'h1);
    rst_b = 1'b0; #1;
    check_output("abort_bvalid_after", {31'b0, bvalid}, 32'h0);
    check_output("abort_pauser", pauser, 32'h0);
    @(negedge clk);
    rst_b = 1'b1;
    n = 0;
    repeat (3) begin @(posedge clk); #1; if (bvalid) n++; end
    check_output("abort_no_response", n, 0);
    axi_read(32'h30, rd);
    check_output("ctl_after_rereset", rd, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
